// File: rtl/btn_cmd_scheduler.sv
// Turns debounced button presses into a ready/valid command stream.
// Directional buttons auto-repeat while held; center issues a single select.
module btn_cmd_scheduler #(
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_calm,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_code,
    output logic       cmd_repeat
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, REPEAT} state_t;

    localparam logic [2:0]  SEL_CENTER = 3'd4;
    localparam logic [25:0] HOLD_LAST  = 26'(HOLD_DELAY - 1);
    localparam logic [25:0] REP_LAST   = 26'(REPEAT_PERIOD - 1);

    state_t      state, state_n;
    logic [4:0]  prev;
    logic [4:0]  pend;
    logic [25:0] cnt, cnt_n;
    logic [2:0]  sel, sel_n;
    logic        rep, rep_n;
    logic [2:0]  pick;
    logic [4:0]  rise;
    logic [4:0]  clr;
    logic [25:0] limit;
    logic        hs;

    assign rise       = btn_calm & ~prev;
    assign cmd_valid  = (state == ISSUE);
    assign cmd_code   = cmd_valid ? (sel + 3'd1) : 3'd0;
    assign cmd_repeat = rep;
    assign hs         = cmd_valid & cmd_ready;
    assign limit      = (state == HOLD) ? HOLD_LAST : REP_LAST;

    // Only fresh presses consume their pending bit; repeats leave pend alone.
    assign clr = (hs && !rep) ? (5'd1 << sel) : 5'd0;

    // Pending priority: center, up, down, left, right.
    always_comb begin
        pick = 3'd0;
        if (pend[4])
            pick = 3'd4;
        else if (pend[0])
            pick = 3'd0;
        else if (pend[1])
            pick = 3'd1;
        else if (pend[2])
            pick = 3'd2;
        else if (pend[3])
            pick = 3'd3;
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        rep_n   = rep;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (pend != 5'd0) begin
                    sel_n   = pick;
                    rep_n   = 1'b0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    if (sel == SEL_CENTER || !btn_calm[sel]) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = 26'd0;
                        state_n = rep ? REPEAT : HOLD;
                    end
                end
            end
            HOLD, REPEAT: begin
                cnt_n = cnt + 26'd1;
                // A new press outranks continuing the current repeat.
                if (!btn_calm[sel]) begin
                    state_n = IDLE;
                end else if (pend != 5'd0) begin
                    state_n = IDLE;
                end else if (cnt == limit) begin
                    state_n = ISSUE;
                    rep_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        prev <= btn_calm;
        if (rst) begin
            state <= IDLE;
            pend  <= 5'd0;
            cnt   <= 26'd0;
            sel   <= 3'd0;
            rep   <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= (pend & ~clr) | rise;
            cnt   <= cnt_n;
            sel   <= sel_n;
            rep   <= rep_n;
        end
    end

endmodule
